imem_inst_loader: RTL and testbench
===================================

Name: imem_inst_loader

Overview:
- Sequential instruction encoder/loader: packs register, funct3, opcode and immediate fields into 32-bit RV32 I-type or S-type words.
- Writes the packed words into instruction memory at consecutive word addresses.
- Performs the inverse of the immediate-extraction path; the decode-side format select (0 = I-type, 1 = S-type) is reused unchanged.
- Sits between the testbench/boot controller and the instruction memory write port; it is active only before the core is released from reset.

Parameters:
- DEPTH, 64, number of 32-bit words the loader may write; sets the full boundary.
- ADDR_W, 6, width of the word address; must satisfy 2^ADDR_W >= DEPTH.
- BASE_ADDR, 0, first word address written after each start.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; opens a load session.
- finish  in  1  one-cycle pulse; closes the session early.
- req_valid  in  1  an encode request is present.
- req_ready  out  1  the loader can accept a request.
- fmt  in  1  0 = I-type, 1 = S-type.
- opcode  in  7  opcode field.
- funct3  in  3  funct3 field.
- rd  in  5  destination register; ignored for S-type.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2; ignored for I-type.
- imm  in  32  signed immediate value.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  encoded instruction.
- mem_rdata  in  32  instruction memory read data (asynchronous read at mem_addr); used only with the optional feature.
- count  out  ADDR_W+1  number of words written this session.
- busy  out  1  a session is open.
- full  out  1  count == DEPTH.
- err  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0; state IDLE; address register = BASE_ADDR.
- Reset mid-session aborts the session; no further writes are issued.
- States:
  - IDLE: req_ready = 0. On start: count <= 0, addr <= BASE_ADDR, err <= 0, go to ACCEPT.
  - ACCEPT: busy = 1; req_ready = 1 unless full.
    - Handshake occurs when req_valid && req_ready. On that edge the packed word is latched.
    - If imm fits signed 12-bit (imm[31:11] all equal), go to WRITE.
    - Otherwise set err, drop the request and stay in ACCEPT.
  - WRITE: mem_we = 1 for exactly one cycle, with mem_addr = addr and mem_wdata = latched word.
    - Next edge: addr <= addr + 1, count <= count + 1.
    - If the new count == DEPTH, go to DONE; otherwise go to ACCEPT.
  - DONE: busy = 0, req_ready = 0; full holds its value. On start, re-initialise as from IDLE.
- Latency: handshake on edge N; mem_we high during cycle N+1. Maximum throughput is one word per 2 cycles.
- Packing:
  - I-type: {imm[11:0], rs1, funct3, rd, opcode}.
  - S-type: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- finish:
  - In ACCEPT: go to DONE next edge.
  - In WRITE: the write still completes, then go to DONE.
- Simultaneous finish and handshake in ACCEPT: the request is accepted and written, then go to DONE.
- start outside IDLE or DONE is ignored.
- Address wraps modulo 2^ADDR_W. This is unreachable while DEPTH <= 2^ADDR_W - BASE_ADDR, which the integrator guarantees.

Optional Feature:
- Macro: IMEM_LOADER_READBACK_EN.
- Defined:
  - Adds a VERIFY state after WRITE.
  - mem_addr holds the just-written address for one cycle.
  - If mem_rdata != the latched word, set err.
  - Counter update moves to the VERIFY exit. Throughput becomes one word per 3 cycles.
- Undefined: no VERIFY state; mem_rdata is unused.

Decomposition:
- Package imem_loader_pkg holds:
  - format constants FMT_I = 1'b0, FMT_S = 1'b1;
  - opcode constants OP_IMM = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  - the state encoding.
- One sub-module, inst_pack: combinational packer with inputs fmt, fields and imm, and outputs the 32-bit word plus an imm_ok flag.

Test Plan:
- addi x1,x0,5 (fmt=0, opcode=0x13, funct3=0, rd=1, rs1=0, imm=5) after start -> mem_we one cycle after handshake, mem_addr=0, mem_wdata=0x00500093, count=1.
- sw x2,8(x0) (fmt=1, opcode=0x23, funct3=2, rs2=2, rs1=0, imm=8) -> mem_wdata=0x00202423 at the next address.
- addi x1,x1,-1 (imm=0xFFFFFFFF) -> mem_wdata=0xFFF08093. Then imm=2048 -> no mem_we, err=1, count unchanged.
- DEPTH=4 with 5 back-to-back requests -> exactly 4 writes at addresses 0..3; full=1; req_ready=0; 5th request never accepted.
- finish asserted in the same cycle as a handshake -> that word is written, then busy=0. A reset asserted during WRITE -> all outputs 0 next cycle.
- With IMEM_LOADER_READBACK_EN defined and memory model forcing bit 0 flipped on read -> err=1 after VERIFY; count still increments.

Source files
------------

// File: rtl/imem_inst_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
// Format select matches the decode side: 0 = I-type, 1 = S-type.
package imem_loader_pkg;

    localparam logic       FMT_I    = 1'b0;
    localparam logic       FMT_S    = 1'b1;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_VERIFY,
        ST_DONE
    } state_t;

endpackage

// File: rtl/imem_inst_loader_if.sv
// Request, control/status and memory write-port bundle for the loader.
// master = boot controller / memory side, slave = the loader.
interface imem_inst_loader_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              finish;
    logic              req_valid;
    logic              req_ready;
    logic              fmt;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              full;
    logic              err;

    modport master (
        output start, finish, req_valid, fmt, opcode, funct3, rd, rs1, rs2, imm, mem_rdata,
        input  req_ready, mem_we, mem_addr, mem_wdata, count, busy, full, err
    );

    modport slave (
        input  start, finish, req_valid, fmt, opcode, funct3, rd, rs1, rs2, imm, mem_rdata,
        output req_ready, mem_we, mem_addr, mem_wdata, count, busy, full, err
    );
endinterface

// File: rtl/imem_inst_loader_inst_pack.sv
// Combinational RV32 I/S-type packer; inverse of the decode immediate extraction.
// o_imm_ok flags immediates that survive truncation to signed 12 bits.
module inst_pack
    import imem_loader_pkg::*;
(
    input  logic        i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_imm_ok
);

    always_comb begin
        o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        if (i_fmt == FMT_S) begin
            o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        end
    end

    // Bits 31..11 must all be copies of the 12-bit sign bit.
    assign o_imm_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);

endmodule

// File: rtl/imem_inst_loader.sv
// Encodes I/S-type requests and writes them to consecutive imem words; one word per 2 cycles.
// Handshake on edge N, mem_we high during cycle N+1; req_ready drops while writing and once full.
// IMEM_LOADER_READBACK_EN adds a VERIFY cycle comparing mem_rdata against the written word.
module imem_inst_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input logic               clk,
    input logic               reset,
    imem_inst_loader_if.slave bus
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_word;
    logic              r_err;
    logic              r_busy;
    logic              r_ready;
    logic              r_we;
    logic              r_full;
    logic              r_fin;

    logic [31:0]       w_word;
    logic              w_imm_ok;
    logic              w_hs;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              w_last;
    logic              w_close;

    inst_pack u_pack (
        .i_fmt    (bus.fmt),
        .i_opcode (bus.opcode),
        .i_funct3 (bus.funct3),
        .i_rd     (bus.rd),
        .i_rs1    (bus.rs1),
        .i_rs2    (bus.rs2),
        .i_imm    (bus.imm),
        .o_word   (w_word),
        .o_imm_ok (w_imm_ok)
    );

    assign w_hs      = bus.req_valid && r_ready;
    assign w_cnt_nxt = r_count + (ADDR_W+1)'(1);
    assign w_last    = (w_cnt_nxt == DEPTH_C);
    // A finish seen at the handshake or during the write closes the session after the word lands.
    assign w_close   = w_last || r_fin || bus.finish;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= BASE_C;
            r_count <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_full  <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_count <= '0;
                        r_addr  <= BASE_C;
                        r_err   <= 1'b0;
                        r_full  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (w_hs && w_imm_ok) begin
                        r_word  <= w_word;
                        r_fin   <= bus.finish;
                        r_we    <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= ST_WRITE;
                    end else if (bus.finish) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= ST_DONE;
                    end
                    if (w_hs && !w_imm_ok) begin
                        r_err <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_READBACK_EN
                ST_WRITE: begin
                    r_fin   <= r_fin | bus.finish;
                    r_state <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (bus.mem_rdata != r_word) begin
                        r_err <= 1'b1;
                    end
`else
                ST_WRITE: begin
`endif
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_count <= w_cnt_nxt;
                    if (w_close) begin
                        r_full  <= w_last;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= ST_ACCEPT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = (r_we || r_state == ST_VERIFY) ? r_addr : '0;
    assign bus.mem_wdata = r_we ? r_word : '0;
    assign bus.count     = r_count;
    assign bus.busy      = r_busy;
    assign bus.full      = r_full;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_imem_inst_loader.sv
// Scenario bench for imem_inst_loader (DEPTH=4): packing, immediate range, full, finish and reset.
module tb_imem_inst_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flip = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [5:0]  exp_addr = '0;
    logic [37:0] exp_q[$];
    logic [37:0] obs_q[$];
    logic [31:0] mem [0:63];

    imem_inst_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_inst_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr] ^ {31'd0, flip};
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    always @(negedge clk) if (bus.mem_we) obs_q.push_back({bus.mem_addr, bus.mem_wdata});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_finish();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
    endtask

    // Presents one request until accepted (bounded); queues the expected write when ok.
    task automatic send(input logic f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] want, input logic ok,
                        input logic fin, output logic took);
        bus.fmt = f; bus.opcode = op; bus.funct3 = f3;
        bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
        bus.req_valid = 1'b1;
        took = 1'b0;
        for (int i = 0; i < 12 && !took; i++) begin
            if (bus.req_ready) begin
                if (ok) begin
                    exp_q.push_back({exp_addr, want});
                    exp_addr = exp_addr + 6'd1;
                end
                bus.finish = fin;
                tick();
                bus.finish = 1'b0;
                took = 1'b1;
            end else begin
                tick();
            end
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string nm);
        int n = 0;
        while (!(bus.req_ready || !bus.busy) && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL %s_timeout: waited %0d cycles, required loader back in ACCEPT/DONE", nm, n);
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.finish = 0; bus.req_valid = 0; bus.fmt = 0; bus.opcode = 0;
        bus.funct3 = 0; bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++;
        if ({bus.req_ready, bus.mem_we, bus.busy, bus.full, bus.err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 00000",
                     {bus.req_ready, bus.mem_we, bus.busy, bus.full, bus.err});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.count} !== 45'd0) begin
            bad++;
            $display("FAIL reset_bus: addr=%0d wdata=%h count=%0d required all 0",
                     bus.mem_addr, bus.mem_wdata, bus.count);
        end
    endtask

    task automatic test_encode();
        logic took;
        logic [37:0] got, want;
        pulse_start();
        exp_addr = '0;
        total++;
        if ({bus.busy, bus.req_ready, bus.count} !== {2'b11, 7'd0}) begin
            bad++;
            $display("FAIL start_state: busy=%b ready=%b count=%0d required 1 1 0",
                     bus.busy, bus.req_ready, bus.count);
        end
        send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1, 1'b0, took);
        wait_quiet("addi");
        total++;
        if (bus.count !== 7'd1) begin
            bad++;
            $display("FAIL addi_count: got %0d required 1", bus.count);
        end
        send(FMT_S, OP_STORE, 3'd2, 5'd0, 5'd0, 5'd2, 32'd8, 32'h00202423, 1'b1, 1'b0, took);
        wait_quiet("sw");
        send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0, 32'hFFFFFFFF, 32'hFFF08093, 1'b1, 1'b0, took);
        wait_quiet("addi_neg");
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL encode_nwrites: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL encode_write: got addr=%0d data=%h required addr=%0d data=%h",
                         got[37:32], got[31:0], want[37:32], want[31:0]);
            end
        end
        send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'd0, 1'b0, 1'b0, took);
        tick();
        total++;
        if ({took, bus.err, bus.busy, bus.count} !== {3'b111, 7'd3}) begin
            bad++;
            $display("FAIL imm_range: took=%b err=%b busy=%b count=%0d required 1 1 1 3",
                     took, bus.err, bus.busy, bus.count);
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL imm_range_write: got %0d writes required 0", obs_q.size());
        end
        pulse_start();
        total++;
        if ({bus.err, bus.count} !== {1'b1, 7'd3}) begin
            bad++;
            $display("FAIL start_ignored: err=%b count=%0d required 1 3", bus.err, bus.count);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        logic [37:0] got, want;
        pulse_finish();
        total++;
        if ({bus.busy, bus.full, bus.count} !== {2'b00, 7'd3}) begin
            bad++;
            $display("FAIL finish_idle: busy=%b full=%b count=%0d required 0 0 3",
                     bus.busy, bus.full, bus.count);
        end
        pulse_start();
        exp_addr = '0;
        total++;
        if ({bus.err, bus.count} !== 8'd0) begin
            bad++;
            $display("FAIL restart: err=%b count=%0d required 0 0", bus.err, bus.count);
        end
        bus.fmt = FMT_I; bus.opcode = OP_IMM; bus.funct3 = 0; bus.rs1 = 0; bus.rs2 = 0;
        bus.rd = 5'd1; bus.imm = 32'd0;
        bus.req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.req_ready && acc < 5) begin
                exp_q.push_back({exp_addr, (32'(acc * 3) << 20) | (32'(acc + 1) << 7) | 32'h13});
                exp_addr = exp_addr + 6'd1;
                tick();
                acc++;
                bus.rd = 5'(acc + 1);
                bus.imm = 32'(acc * 3);
            end else begin
                tick();
            end
        end
        bus.req_valid = 1'b0;
        total++;
        if (acc != DEPTH) begin
            bad++;
            $display("FAIL full_accepts: got %0d required %0d", acc, DEPTH);
        end
        total++;
        if ({bus.full, bus.req_ready, bus.busy, bus.count} !== {3'b100, 7'd4}) begin
            bad++;
            $display("FAIL full_state: full=%b ready=%b busy=%b count=%0d required 1 0 0 4",
                     bus.full, bus.req_ready, bus.busy, bus.count);
        end
        total++;
        if (obs_q.size() != DEPTH) begin
            bad++;
            $display("FAIL full_nwrites: got %0d required %0d", obs_q.size(), DEPTH);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL full_write: got addr=%0d data=%h required addr=%0d data=%h",
                         got[37:32], got[31:0], want[37:32], want[31:0]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_finish_same();
        logic took;
        logic [37:0] got, want;
        pulse_start();
        exp_addr = '0;
        send(FMT_S, OP_STORE, 3'd2, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC, 32'hFE512E23, 1'b1, 1'b1, took);
        wait_quiet("finish_same");
        total++;
        if ({took, bus.busy, bus.full, bus.count} !== {3'b100, 7'd1}) begin
            bad++;
            $display("FAIL finish_same_state: took=%b busy=%b full=%b count=%0d required 1 0 0 1",
                     took, bus.busy, bus.full, bus.count);
        end
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL finish_same_nwrites: got %0d required 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL finish_same_write: got addr=%0d data=%h required addr=%0d data=%h",
                         got[37:32], got[31:0], want[37:32], want[31:0]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_write();
        logic took;
        pulse_start();
        exp_addr = '0;
        send(FMT_I, OP_LOAD, 3'd2, 5'd3, 5'd4, 5'd0, 32'd16, 32'h01022183, 1'b1, 1'b0, took);
        total++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 6'd0, 32'h01022183}) begin
            bad++;
            $display("FAIL write_latency: we=%b addr=%0d data=%h required 1 0 01022183",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({bus.req_ready, bus.mem_we, bus.busy, bus.full, bus.err, bus.mem_addr,
             bus.mem_wdata, bus.count} !== 50'd0) begin
            bad++;
            $display("FAIL reset_mid_write: ready=%b we=%b busy=%b count=%0d data=%h required all 0",
                     bus.req_ready, bus.mem_we, bus.busy, bus.count, bus.mem_wdata);
        end
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        repeat (5) tick();
        total++;
        if (obs_q.size() != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL after_reset_quiet: writes=%0d busy=%b required 0 0", obs_q.size(), bus.busy);
        end
    endtask

    task automatic test_readback();
`ifdef IMEM_LOADER_READBACK_EN
        logic took;
        pulse_start();
        exp_addr = '0;
        flip = 1'b1;
        send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1, 1'b0, took);
        wait_quiet("readback");
        flip = 1'b0;
        total++;
        if ({bus.err, bus.count} !== {1'b1, 7'd1}) begin
            bad++;
            $display("FAIL readback_err: err=%b count=%0d required 1 1", bus.err, bus.count);
        end
        obs_q.delete();
        exp_q.delete();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_encode();
        test_back_to_back();
        test_finish_same();
        test_reset_write();
        test_readback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
